avalon_mem_if_arbiter2: RTL and testbench

AVALON_MEM_IF_ARBITER2 -- requirements
Module: avalon_mem_if_arbiter2

---
 rtl/avmm_arb_pkg.sv | 29 ++
 rtl/local_mem_cfg_pkg.sv | 9 +
 rtl/avmm_arb_tag_fifo.sv | 56 +++++
 rtl/avalon_mem_if_arbiter2.sv | 183 ++++++++++++++++++
 tb/tb_avalon_mem_if_arbiter2.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/avmm_arb_pkg.sv
// rtl/avmm_arb_pkg.sv - shared types for the two-requester Avalon-MM arbiter
package avmm_arb_pkg;

  typedef enum logic {
    REQ_S0 = 1'b0,
    REQ_S1 = 1'b1
  } req_id_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_WBURST = 1'b1
  } arb_state_t;

  // Tag burst field is wide enough for any practical burstcount width.
  localparam int TAG_BC_WIDTH = 16;
  typedef logic [TAG_BC_WIDTH-1:0] tag_bc_t;

  typedef struct packed {
    req_id_t id;
    tag_bc_t bcnt;
  } tag_entry_t;

  localparam int TAG_ENTRY_WIDTH = $bits(tag_entry_t);

  function automatic req_id_t other_req(input req_id_t r);
    return (r == REQ_S0) ? REQ_S1 : REQ_S0;
  endfunction

endpackage

// File: rtl/local_mem_cfg_pkg.sv
// rtl/local_mem_cfg_pkg.sv - default geometry of the local memory port
package local_mem_cfg_pkg;

  localparam int LMEM_DATA_WIDTH      = 32;
  localparam int LMEM_ADDR_WIDTH      = 10;
  localparam int LMEM_BURST_CNT_WIDTH = 4;
  localparam int LMEM_TAG_FIFO_DEPTH  = 16;

endpackage

// File: rtl/avmm_arb_tag_fifo.sv
// rtl/avmm_arb_tag_fifo.sv - show-ahead FIFO of outstanding read-burst tags
module avmm_arb_tag_fifo
  import avmm_arb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [TAG_ENTRY_WIDTH-1:0] push_data,
  input  logic                       pop,
  output logic [TAG_ENTRY_WIDTH-1:0] head,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [TAG_ENTRY_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]              wr_ptr;
  logic [AW-1:0]              rd_ptr;
  logic [AW:0]                count;
  logic                       do_push;
  logic                       do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Storage array: written on push, never reset (validity is tracked by count).
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/avalon_mem_if_arbiter2.sv
// rtl/avalon_mem_if_arbiter2.sv - round-robin share of one Avalon-MM port between s0 and s1
module avalon_mem_if_arbiter2
  import avmm_arb_pkg::*;
#(
  parameter int DATA_WIDTH      = local_mem_cfg_pkg::LMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH      = local_mem_cfg_pkg::LMEM_ADDR_WIDTH,
  parameter int BURST_CNT_WIDTH = local_mem_cfg_pkg::LMEM_BURST_CNT_WIDTH,
  parameter int TAG_FIFO_DEPTH  = local_mem_cfg_pkg::LMEM_TAG_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s0_read,
  input  logic                       s0_write,
  input  logic [ADDR_WIDTH-1:0]      s0_address,
  input  logic [BURST_CNT_WIDTH-1:0] s0_burstcount,
  input  logic [DATA_WIDTH-1:0]      s0_writedata,
  input  logic [DATA_WIDTH/8-1:0]    s0_byteenable,
  output logic                       s0_waitrequest,
  output logic [DATA_WIDTH-1:0]      s0_readdata,
  output logic                       s0_readdatavalid,
  input  logic                       s1_read,
  input  logic                       s1_write,
  input  logic [ADDR_WIDTH-1:0]      s1_address,
  input  logic [BURST_CNT_WIDTH-1:0] s1_burstcount,
  input  logic [DATA_WIDTH-1:0]      s1_writedata,
  input  logic [DATA_WIDTH/8-1:0]    s1_byteenable,
  output logic                       s1_waitrequest,
  output logic [DATA_WIDTH-1:0]      s1_readdata,
  output logic                       s1_readdatavalid,
  output logic                       m_read,
  output logic                       m_write,
  output logic [ADDR_WIDTH-1:0]      m_address,
  output logic [BURST_CNT_WIDTH-1:0] m_burstcount,
  output logic [DATA_WIDTH-1:0]      m_writedata,
  output logic [DATA_WIDTH/8-1:0]    m_byteenable,
  input  logic                       m_waitrequest,
  input  logic [DATA_WIDTH-1:0]      m_readdata,
  input  logic                       m_readdatavalid
);

  arb_state_t                 state;
  arb_state_t                 state_next;
  req_id_t                    last_grant;
  req_id_t                    grant;
  logic                       grant_valid;
  logic                       s0_elig;
  logic                       s1_elig;
  logic                       accept;
  logic                       burst_start;
  logic [BURST_CNT_WIDTH-1:0] beats_left;
  tag_bc_t                    beat_cnt;
  logic                       tag_full;
  logic                       tag_empty;
  logic                       tag_push;
  logic                       tag_pop;
  logic                       rsp_beat;
  tag_entry_t                 tag_in;
  tag_entry_t                 tag_head;
  logic [TAG_ENTRY_WIDTH-1:0] tag_head_bits;

  // A read request only competes while there is room for its tag.
  assign s0_elig = s0_write || (s0_read && !tag_full);
  assign s1_elig = s1_write || (s1_read && !tag_full);

  assign accept      = (m_read || m_write) && !m_waitrequest;
  assign burst_start = (state == ST_IDLE) && accept && m_write
                       && (m_burstcount > BURST_CNT_WIDTH'(1));

  // Grant selection: locked to the burst owner in WBURST, round-robin on ties in IDLE.
  always_comb begin
    grant       = REQ_S0;
    grant_valid = 1'b0;
    if (state == ST_WBURST) begin
      grant       = last_grant;
      grant_valid = 1'b1;
    end else if (s0_elig && s1_elig) begin
      grant       = other_req(last_grant);
      grant_valid = 1'b1;
    end else if (s0_elig) begin
      grant       = REQ_S0;
      grant_valid = 1'b1;
    end else if (s1_elig) begin
      grant       = REQ_S1;
      grant_valid = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state: enter WBURST on a multi-beat first write, leave on its last beat.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (burst_start) state_next = ST_WBURST;
      ST_WBURST: if (accept && m_write && beats_left == BURST_CNT_WIDTH'(1)) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs: zero-latency command mux and response routing, all quiet in reset.
  always_comb begin
    m_address        = (grant == REQ_S1) ? s1_address    : s0_address;
    m_burstcount     = (grant == REQ_S1) ? s1_burstcount : s0_burstcount;
    m_writedata      = (grant == REQ_S1) ? s1_writedata  : s0_writedata;
    m_byteenable     = (grant == REQ_S1) ? s1_byteenable : s0_byteenable;
    m_read           = 1'b0;
    m_write          = 1'b0;
    s0_waitrequest   = 1'b1;
    s1_waitrequest   = 1'b1;
    s0_readdata      = m_readdata;
    s1_readdata      = m_readdata;
    s0_readdatavalid = 1'b0;
    s1_readdatavalid = 1'b0;
    if (!reset && grant_valid) begin
      m_read  = ((grant == REQ_S1) ? s1_read : s0_read) && !tag_full && (state == ST_IDLE);
      m_write = (grant == REQ_S1) ? s1_write : s0_write;
      if (grant == REQ_S1) s1_waitrequest = m_waitrequest;
      else                 s0_waitrequest = m_waitrequest;
    end
    if (rsp_beat) begin
      s0_readdatavalid = (tag_head.id == REQ_S0);
      s1_readdatavalid = (tag_head.id == REQ_S1);
    end
  end

  // Round-robin pointer and remaining write-burst beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= REQ_S1;
      beats_left <= '0;
    end else begin
      if (accept) last_grant <= grant;
      if (burst_start) begin
        beats_left <= m_burstcount - 1'b1;
      end else if (state == ST_WBURST && accept && m_write) begin
        beats_left <= beats_left - 1'b1;
      end
    end
  end

  assign tag_push      = accept && m_read;
  assign tag_in        = '{id: grant, bcnt: tag_bc_t'(m_burstcount)};
  assign tag_head      = tag_entry_t'(tag_head_bits);
  assign rsp_beat      = !reset && m_readdatavalid && !tag_empty;
  assign tag_pop       = rsp_beat && ((beat_cnt + tag_bc_t'(1)) == tag_head.bcnt);

  // Count beats of the head burst; the tag pops on its last beat.
  always_ff @(posedge clk) begin
    if (reset)         beat_cnt <= '0;
    else if (tag_pop)  beat_cnt <= '0;
    else if (rsp_beat) beat_cnt <= beat_cnt + tag_bc_t'(1);
  end

  avmm_arb_tag_fifo #(
    .DEPTH (TAG_FIFO_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tag_push),
    .push_data (tag_in),
    .pop       (tag_pop),
    .head      (tag_head_bits),
    .full      (tag_full),
    .empty     (tag_empty)
  );

`ifndef SYNTHESIS
  // Protocol violations that the arbiter cannot recover from.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (m_readdatavalid && tag_empty)
        $fatal(1, "avalon_mem_if_arbiter2: readdatavalid with no outstanding read");
      if ((m_read || m_write) && m_burstcount == '0)
        $fatal(1, "avalon_mem_if_arbiter2: burstcount of zero on a command");
    end
  end
`endif

endmodule

// File: tb/tb_avalon_mem_if_arbiter2.sv
// tb/tb_avalon_mem_if_arbiter2.sv - directed bench with a queue-based reference model
module tb_avalon_mem_if_arbiter2;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int BW    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          reset;
  logic          s0_read, s0_write, s1_read, s1_write;
  logic [AW-1:0] s0_address, s1_address;
  logic [BW-1:0] s0_burstcount, s1_burstcount;
  logic [DW-1:0] s0_writedata, s1_writedata;
  logic [3:0]    s0_byteenable, s1_byteenable;
  logic          s0_waitrequest, s1_waitrequest;
  logic [DW-1:0] s0_readdata, s1_readdata;
  logic          s0_readdatavalid, s1_readdatavalid;
  logic          m_read, m_write;
  logic [AW-1:0] m_address;
  logic [BW-1:0] m_burstcount;
  logic [DW-1:0] m_writedata;
  logic [3:0]    m_byteenable;
  logic          m_waitrequest;
  logic [DW-1:0] m_readdata;
  logic          m_readdatavalid;

  int n_cmp = 0;
  int n_bad = 0;
  int c0 = 0;
  int c1 = 0;

  avalon_mem_if_arbiter2 #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_CNT_WIDTH(BW), .TAG_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .s0_read(s0_read), .s0_write(s0_write), .s0_address(s0_address),
    .s0_burstcount(s0_burstcount), .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable),
    .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
    .s1_read(s1_read), .s1_write(s1_write), .s1_address(s1_address),
    .s1_burstcount(s1_burstcount), .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
    .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_burstcount(m_burstcount),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int id;
    int bc;
  } tag_t;

  // Reference model: outstanding bursts as a queue, grant lock as an owner id.
  tag_t tq[$];
  int   lg = 1;
  int   lock = -1;
  int   left = 0;
  int   cnt = 0;

  always @(negedge clk) begin : model
    int   g, gv, full_q, e0, e1, er, ew, hv, bc;
    tag_t t;
    if (reset) begin
      chk("rst_m_read", m_read, 0);
      chk("rst_m_write", m_write, 0);
      chk("rst_s0_waitrequest", s0_waitrequest, 1);
      chk("rst_s1_waitrequest", s1_waitrequest, 1);
      chk("rst_s0_readdatavalid", s0_readdatavalid, 0);
      chk("rst_s1_readdatavalid", s1_readdatavalid, 0);
      lg = 1; lock = -1; left = 0; cnt = 0;
      tq.delete();
    end else begin
      full_q = (tq.size() >= DEPTH) ? 1 : 0;
      e0 = (s0_write || (s0_read && full_q == 0)) ? 1 : 0;
      e1 = (s1_write || (s1_read && full_q == 0)) ? 1 : 0;
      gv = 1;
      if (lock >= 0)             g = lock;
      else if (e0 == 1 && e1 == 1) g = 1 - lg;
      else if (e0 == 1)          g = 0;
      else if (e1 == 1)          g = 1;
      else begin g = 0; gv = 0; end
      er = (gv == 1 && lock < 0 && full_q == 0 && ((g == 1) ? s1_read : s0_read)) ? 1 : 0;
      ew = (gv == 1 && ((g == 1) ? s1_write : s0_write)) ? 1 : 0;
      bc = (g == 1) ? int'(s1_burstcount) : int'(s0_burstcount);
      chk("m_read", m_read, er);
      chk("m_write", m_write, ew);
      chk("s0_waitrequest", s0_waitrequest, (gv == 1 && g == 0) ? m_waitrequest : 1'b1);
      chk("s1_waitrequest", s1_waitrequest, (gv == 1 && g == 1) ? m_waitrequest : 1'b1);
      if (er == 1 || ew == 1) begin
        chk("m_address", m_address, (g == 1) ? s1_address : s0_address);
        chk("m_burstcount", m_burstcount, bc);
        if (ew == 1) begin
          chk("m_writedata", m_writedata, (g == 1) ? s1_writedata : s0_writedata);
          chk("m_byteenable", m_byteenable, (g == 1) ? s1_byteenable : s0_byteenable);
        end
      end
      hv = (m_readdatavalid && tq.size() > 0) ? 1 : 0;
      chk("s0_readdatavalid", s0_readdatavalid, (hv == 1 && tq[0].id == 0) ? 1 : 0);
      chk("s1_readdatavalid", s1_readdatavalid, (hv == 1 && tq[0].id == 1) ? 1 : 0);
      if (hv == 1) begin
        chk("s0_readdata", s0_readdata, m_readdata);
        chk("s1_readdata", s1_readdata, m_readdata);
      end
      if ((er == 1 || ew == 1) && !m_waitrequest) begin
        lg = g;
        if (ew == 1) begin
          if (lock < 0) begin
            if (bc > 1) begin lock = g; left = bc - 1; end
          end else begin
            left--;
            if (left == 0) lock = -1;
          end
        end
        if (er == 1) begin t.id = g; t.bc = bc; tq.push_back(t); end
      end
      if (hv == 1) begin
        cnt++;
        if (cnt == tq[0].bc) begin
          void'(tq.pop_front());
          cnt = 0;
        end
      end
    end
  end

  // Tally of read beats delivered by the DUT to each requester.
  always @(negedge clk) begin
    if (!reset) begin
      c0 += int'(s0_readdatavalid);
      c1 += int'(s1_readdatavalid);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1;
    reset = 1'b1;
    {s0_read, s0_write, s1_read, s1_write} = '0;
    s0_address = 10'h010; s1_address = 10'h020;
    s0_burstcount = 4'd1; s1_burstcount = 4'd1;
    s0_writedata = '0; s1_writedata = '0;
    s0_byteenable = 4'hF; s1_byteenable = 4'h3;
    m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;
    step(); step();
    s0_read = 1'b1;
    #1;
    chk("lit_reset_s0_wait", s0_waitrequest, 1);
    chk("lit_reset_m_read", m_read, 0);
    step();

    // Simultaneous single reads: s0 first, then s1; data routed in that order.
    reset = 1'b0; s1_read = 1'b1;
    #1;
    chk("lit_tie_s0_wait", s0_waitrequest, 0);
    chk("lit_tie_s1_wait", s1_waitrequest, 1);
    chk("lit_tie_addr", m_address, 10'h010);
    step(); s0_read = 1'b0;
    #1;
    chk("lit_s1_second_wait", s1_waitrequest, 0);
    chk("lit_s1_second_addr", m_address, 10'h020);
    step(); s1_read = 1'b0;
    step(); m_readdatavalid = 1'b1; m_readdata = 32'hA;
    #1;
    chk("lit_rsp0_s0", s0_readdatavalid, 1);
    chk("lit_rsp0_s1", s1_readdatavalid, 0);
    step(); m_readdata = 32'hB;
    #1;
    chk("lit_rsp1_s1", s1_readdatavalid, 1);
    chk("lit_rsp1_data", s1_readdata, 32'hB);
    step(); m_readdatavalid = 1'b0;

    // s1 write burst of 4 holds the port while s0 waits with a read.
    s1_write = 1'b1; s1_burstcount = 4'd4; s1_writedata = 32'h1;
    #1; chk("lit_wb_first", s1_waitrequest, 0);
    step(); s1_writedata = 32'h2; s0_read = 1'b1; s0_address = 10'h030;
    #1; chk("lit_wb_s0_held", s0_waitrequest, 1);
    step(); s1_writedata = 32'h3;
    step(); s1_writedata = 32'h4;
    #1; chk("lit_wb_last_data", m_writedata, 32'h4);
    step(); s1_write = 1'b0; s1_burstcount = 4'd1;
    #1;
    chk("lit_wb_s0_next", s0_waitrequest, 0);
    chk("lit_wb_s0_addr", m_address, 10'h030);
    step(); s0_read = 1'b0;
    m_readdatavalid = 1'b1; m_readdata = 32'hC;
    step(); m_readdatavalid = 1'b0;

    // Memory stall mid write burst; s1 must not slip in.
    s0_write = 1'b1; s0_burstcount = 4'd3; s0_writedata = 32'h100;
    step(); s0_writedata = 32'h101; m_waitrequest = 1'b1;
    s1_write = 1'b1; s1_writedata = 32'h200;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lit_stall_data", m_writedata, 32'h101);
      chk("lit_stall_s1_wait", s1_waitrequest, 1);
      step();
    end
    m_waitrequest = 1'b0;
    step(); s0_writedata = 32'h102;
    #1; chk("lit_stall_last_s1_wait", s1_waitrequest, 1);
    step(); s0_write = 1'b0; s0_burstcount = 4'd1;
    #1; chk("lit_stall_s1_after", m_writedata, 32'h200);
    step(); s1_write = 1'b0;

    // s0 read burst of 8 and s1 read burst of 2.
    s0_read = 1'b1; s0_burstcount = 4'd8; s1_read = 1'b1; s1_burstcount = 4'd2;
    #1; chk("lit_b8_s0_first", s0_waitrequest, 0);
    step(); s0_read = 1'b0;
    step(); s1_read = 1'b0;
    b0 = c0; b1 = c1;
    for (int i = 0; i < 10; i++) begin
      m_readdatavalid = 1'b1; m_readdata = 32'h50 + i;
      #1;
      if (i < 8) chk("lit_b8_route_s0", s0_readdatavalid, 1);
      else       chk("lit_b2_route_s1", s1_readdatavalid, 1);
      step();
    end
    m_readdatavalid = 1'b0;
    step();
    chk("lit_b8_count", c0 - b0, 8);
    chk("lit_b2_count", c1 - b1, 2);

    // Fill the tag FIFO with 16 two-beat reads; the 17th waits for the first pop.
    s0_read = 1'b1; s0_burstcount = 4'd2; s1_burstcount = 4'd1;
    for (int i = 0; i < 16; i++) begin
      #1; chk("lit_fill_accept", s0_waitrequest, 0);
      step();
    end
    s1_write = 1'b1; s1_writedata = 32'h300;
    m_readdatavalid = 1'b1; m_readdata = 32'h600;
    #1;
    chk("lit_full_s0_wait", s0_waitrequest, 1);
    chk("lit_full_m_read", m_read, 0);
    chk("lit_full_write_ok", s1_waitrequest, 0);
    step(); s1_write = 1'b0; m_readdata = 32'h601;
    #1;
    chk("lit_full_pop_cycle_wait", s0_waitrequest, 1);
    step(); m_readdatavalid = 1'b0;
    #1;
    chk("lit_full_release", s0_waitrequest, 0);
    chk("lit_full_release_read", m_read, 1);
    step(); s0_read = 1'b0;
    for (int i = 0; i < 32; i++) begin
      m_readdatavalid = 1'b1; m_readdata = 32'h700 + i;
      step();
    end
    m_readdatavalid = 1'b0;
    step();

    // Reset in the middle of a write burst discards the lock and tags.
    s1_write = 1'b1; s1_burstcount = 4'd4; s1_writedata = 32'h400;
    step(); s1_writedata = 32'h401;
    #1; chk("lit_rb_burst_owner", s1_waitrequest, 0);
    reset = 1'b1;
    #1;
    chk("lit_rb_rst_m_write", m_write, 0);
    chk("lit_rb_rst_s1_wait", s1_waitrequest, 1);
    step(); reset = 1'b0; s1_write = 1'b0; s1_burstcount = 4'd1; s0_burstcount = 4'd1;
    s0_read = 1'b1; s1_read = 1'b1; s0_address = 10'h011; s1_address = 10'h022;
    #1;
    chk("lit_rb_s0_wins", s0_waitrequest, 0);
    chk("lit_rb_s1_waits", s1_waitrequest, 1);
    chk("lit_rb_addr", m_address, 10'h011);
    step(); s0_read = 1'b0;
    step(); s1_read = 1'b0;
    m_readdatavalid = 1'b1; m_readdata = 32'hD;
    #1; chk("lit_rb_rsp_s0", s0_readdatavalid, 1);
    step(); m_readdata = 32'hE;
    #1; chk("lit_rb_rsp_s1", s1_readdatavalid, 1);
    step(); m_readdatavalid = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
